// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start / slew controller around an R-bit PWM counter.
// A target duty is accepted over valid/ready, held in a shadow register, and
// applied at the next period boundary. The applied duty then walks toward the
// target by STEP every RAMP_DIV periods, so no pulse is ever truncated.
module pwm_ramp_ctrl #(
  parameter int R        = 8,
  parameter int STEP     = 1,
  parameter int RAMP_DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         cmd_valid,
  input  logic [R:0]   cmd_duty,
  output logic         cmd_ready,
  output logic         pwm_out,
  output logic [R:0]   duty_applied,
  output logic         period_start,
  output logic         ramping,
  output logic         done
);

  // 100% duty is 2^R, one bit wider than the counter.
  localparam logic [R:0]   FULL    = {1'b1, {R{1'b0}}};
  localparam logic [R-1:0] CNT_MAX = '1;

  localparam int PC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(RAMP_DIV - 1);

  // A step larger than full scale behaves the same as a full-scale step.
  localparam int         STEP_C = (STEP > (2 ** R)) ? (2 ** R) : STEP;
  localparam logic [R:0] STEP_V = (R + 1)'(STEP_C);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  // Commands above full scale saturate at 100%.
  function automatic logic [R:0] clamp_duty(input logic [R:0] d);
    return (d > FULL) ? FULL : d;
  endfunction

  // One ramp step toward tgt; the increment never exceeds the remaining
  // distance, so the result cannot overshoot, overflow or underflow.
  // STEP of 0 means "close the whole gap in one step".
  function automatic logic [R:0] step_toward(input logic [R:0] cur,
                                             input logic [R:0] tgt);
    logic [R:0] diff;
    logic [R:0] inc;
    diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
    inc  = ((STEP_V == '0) || (diff < STEP_V)) ? diff : STEP_V;
    return (tgt >= cur) ? (cur + inc) : (cur - inc);
  endfunction

  state_t            state_q, state_d;
  logic [R-1:0]      cnt_q, cnt_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [R:0]        duty_q, duty_d;
  logic [R:0]        target_q, target_d;
  logic [R:0]        shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic              pwm_q, pwm_d;
  logic              ps_q, ps_d;
  logic              done_q, done_d;
  logic              boundary;
  logic              accept;
  logic [R:0]        nxt_duty;

  // Ready drops during reset even though pending is already clear.
  assign cmd_ready    = ~reset & ~pending_q;
  assign accept       = cmd_valid & cmd_ready;
  assign boundary     = en & (cnt_q == CNT_MAX);

  assign pwm_out      = pwm_q;
  assign duty_applied = duty_q;
  assign period_start = ps_q;
  assign ramping      = (state_q == RAMP);
  assign done         = done_q;

  // Next-state logic: counter, handshake, boundary retarget and ramp stepping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    duty_d    = duty_q;
    target_d  = target_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    pwm_d     = en & ({1'b0, cnt_q} < duty_q);
    ps_d      = boundary;
    done_d    = 1'b0;
    nxt_duty  = step_toward(duty_q, target_q);

    // A command taken in a boundary cycle is only seen by the next boundary,
    // because the retarget below looks at pending_q, not pending_d.
    if (accept) begin
      shadow_d  = clamp_duty(cmd_duty);
      pending_d = 1'b1;
    end

    if (!en) begin
      // Disabled: output forced low and ramp restarts from zero later;
      // target/shadow/pending survive.
      cnt_d   = '0;
      pc_d    = '0;
      duty_d  = '0;
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (boundary) begin
        if (pending_q) begin
          // Retarget: no step on this boundary, divider restarts.
          target_d  = shadow_q;
          pending_d = 1'b0;
          pc_d      = '0;
          state_d   = (shadow_q == duty_q) ? IDLE : RAMP;
        end else if (state_q == RAMP) begin
          if (pc_q == PC_LAST) begin
            pc_d   = '0;
            duty_d = nxt_duty;
            if (nxt_duty == target_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end else if (duty_q != target_q) begin
          // Re-enable after en dropped: soft start from zero toward the old target.
          state_d = RAMP;
          pc_d    = '0;
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pc_q      <= '0;
      duty_q    <= '0;
      target_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      pwm_q     <= 1'b0;
      ps_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      duty_q    <= duty_d;
      target_q  <= target_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl (R=4, STEP=4, RAMP_DIV=2), with a STEP=0
// instance sharing the same stimulus to show the single-jump behaviour.
// cyc counts rising edges after reset is released; the counter value after
// edge k is k mod 16 while en stays high from cyc 0.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       cmd_valid;
  logic [4:0] cmd_duty;

  logic       cmd_ready, pwm_out, period_start, ramping, done;
  logic [4:0] duty_applied;
  logic       cmd_ready0, pwm_out0, period_start0, ramping0, done0;
  logic [4:0] duty_applied0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int high;

  pwm_ramp_ctrl #(.R(4), .STEP(4), .RAMP_DIV(2)) dut (
    .clk(clk), .reset(reset), .en(en), .cmd_valid(cmd_valid), .cmd_duty(cmd_duty),
    .cmd_ready(cmd_ready), .pwm_out(pwm_out), .duty_applied(duty_applied),
    .period_start(period_start), .ramping(ramping), .done(done)
  );

  pwm_ramp_ctrl #(.R(4), .STEP(0), .RAMP_DIV(2)) dut0 (
    .clk(clk), .reset(reset), .en(en), .cmd_valid(cmd_valid), .cmd_duty(cmd_duty),
    .cmd_ready(cmd_ready0), .pwm_out(pwm_out0), .duty_applied(duty_applied0),
    .period_start(period_start0), .ramping(ramping0), .done(done0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int e);
    while (cyc < e) tick();
  endtask

  task automatic measure(input int n, output int h);
    h = 0;
    repeat (n) begin
      tick();
      h += int'(pwm_out);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [4:0] d);
    cmd_valid = 1'b1;
    cmd_duty  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; cmd_valid = 1'b0; cmd_duty = '0;

    // 1: reset
    repeat (3) tick();
    chk("rst_pwm",   32'(pwm_out), 0);
    chk("rst_duty",  32'(duty_applied), 0);
    chk("rst_ps",    32'(period_start), 0);
    chk("rst_ramp",  32'(ramping), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_ready", 32'(cmd_ready), 0);
    reset = 1'b0; en = 1'b1; cyc = 0;
    #1;
    chk("ready_after_rst", 32'(cmd_ready), 1);

    // 2: ramp 0 -> 12, command offered while cnt==3
    run_to(3);
    send(5'd12);
    chk("t2_ready_low", 32'(cmd_ready), 0);
    chk("t2_ready_low_s0", 32'(cmd_ready0), 0);
    run_to(15);
    chk("t2_ready_b0", 32'(cmd_ready), 0);
    chk("t2_ps_b0", 32'(period_start), 0);
    run_to(16);
    chk("t2_ready_b1", 32'(cmd_ready), 1);
    chk("t2_ps_b1", 32'(period_start), 1);
    chk("t2_ramping_b1", 32'(ramping), 1);
    chk("t2_duty_b1", 32'(duty_applied), 0);
    run_to(17);
    chk("t2_ps_pulse", 32'(period_start), 0);
    run_to(47);
    chk("t2_duty_pre3", 32'(duty_applied), 0);
    chk("s0_duty_pre3", 32'(duty_applied0), 0);
    run_to(48);
    chk("t2_duty_b3", 32'(duty_applied), 4);
    chk("s0_duty_b3", 32'(duty_applied0), 12);
    chk("s0_ramping_b3", 32'(ramping0), 0);
    chk("s0_done_b3", 32'(done0), 1);
    measure(16, high);
    chk("t2_high4", 32'(high), 4);
    run_to(80);
    chk("t2_duty_b5", 32'(duty_applied), 8);
    measure(16, high);
    chk("t2_high8", 32'(high), 8);
    run_to(111);
    chk("t2_done_pre", 32'(done), 0);
    chk("t2_ramping_pre", 32'(ramping), 1);
    run_to(112);
    chk("t2_duty_b7", 32'(duty_applied), 12);
    chk("t2_ramping_end", 32'(ramping), 0);
    chk("t2_done", 32'(done), 1);
    run_to(113);
    chk("t2_done_once", 32'(done), 0);
    run_to(112 + 1);
    measure(15, high);
    high += 1;  // sample after edge 113 (cnt 0 < 12) was already high
    chk("t2_pwm_e113", 32'(high), 12);

    // 3: 12 -> 2, last step clamped
    send(5'd2);
    run_to(176);
    chk("t3_duty8", 32'(duty_applied), 8);
    run_to(208);
    chk("t3_duty4", 32'(duty_applied), 4);
    run_to(239);
    chk("t3_ramping", 32'(ramping), 1);
    run_to(240);
    chk("t3_duty2", 32'(duty_applied), 2);
    chk("t3_ramping_end", 32'(ramping), 0);
    chk("t3_done", 32'(done), 1);
    measure(16, high);
    chk("t3_high2", 32'(high), 2);

    // 4: 20 clamps to 16 (always high), then 0 (always low)
    send(5'd20);
    run_to(400);
    chk("t4_duty16", 32'(duty_applied), 16);
    chk("t4_done16", 32'(done), 1);
    measure(16, high);
    chk("t4_high16", 32'(high), 16);
    run_to(417);
    chk("t4_pwm_wrap", 32'(pwm_out), 1);
    send(5'd0);
    run_to(464);
    chk("t4_duty12", 32'(duty_applied), 12);
    run_to(560);
    chk("t4_duty0", 32'(duty_applied), 0);
    chk("t4_done0", 32'(done), 1);
    measure(16, high);
    chk("t4_high0", 32'(high), 0);
    run_to(577);
    chk("t4_pwm_low", 32'(pwm_out), 0);

    // 5: retarget mid-ramp, then accept inside a boundary cycle
    send(5'd12);
    run_to(656);
    chk("t5_duty8", 32'(duty_applied), 8);
    send(5'd0);
    run_to(688);
    chk("t5_no_overshoot", 32'(duty_applied), 8);
    run_to(704);
    chk("t5_rev4", 32'(duty_applied), 4);
    run_to(736);
    chk("t5_rev0", 32'(duty_applied), 0);
    chk("t5_done", 32'(done), 1);
    run_to(751);
    send(5'd12);
    chk("t5_bnd_ready", 32'(cmd_ready), 0);
    chk("t5_bnd_idle", 32'(ramping), 0);
    run_to(767);
    chk("t5_bnd_not_yet", 32'(ramping), 0);
    run_to(768);
    chk("t5_bnd_applied", 32'(ramping), 1);
    run_to(800);
    chk("t5_duty4", 32'(duty_applied), 4);
    run_to(832);
    chk("t5_duty8b", 32'(duty_applied), 8);

    // 6: disable at duty 8, then soft start repeats toward 12
    run_to(834);
    chk("t6_pwm_hi", 32'(pwm_out), 1);
    en = 1'b0;
    tick();
    chk("t6_pwm_off", 32'(pwm_out), 0);
    chk("t6_duty_off", 32'(duty_applied), 0);
    chk("t6_ramp_off", 32'(ramping), 0);
    run_to(840);
    chk("t6_ps_off", 32'(period_start), 0);
    en = 1'b1;
    run_to(856);
    chk("t6_rearm", 32'(ramping), 1);
    chk("t6_duty0", 32'(duty_applied), 0);
    run_to(888);
    chk("t6_duty4", 32'(duty_applied), 4);
    run_to(920);
    chk("t6_duty8", 32'(duty_applied), 8);
    run_to(952);
    chk("t6_duty12", 32'(duty_applied), 12);
    chk("t6_done", 32'(done), 1);

    // Reset in the middle of a ramp
    send(5'd0);
    run_to(970);
    chk("rst_mid_ramping", 32'(ramping), 1);
    reset = 1'b1;
    tick();
    chk("rst_mid_duty", 32'(duty_applied), 0);
    chk("rst_mid_ramp", 32'(ramping), 0);
    chk("rst_mid_ready", 32'(cmd_ready), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
